// File: rtl/piso_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : piso_serializer                                              |
// | Description : Parallel-in serial-out transmitter with valid/ready input,   |
// |               registered q/qb, frame and done. Optional even-parity bit    |
// |               enabled by the PIS_PARITY_EN macro.                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  output logic             d_ready,
  output logic             q,
  output logic             qb,
  output logic             frame,
  output logic             done
);

  localparam int              c_cw      = $clog2(WIDTH);
  localparam logic [c_cw-1:0] c_cnt_max = c_cw'(WIDTH - 1);
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [c_cw-1:0]  r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_q, w_q_nxt;
  logic             r_frame, w_frame_nxt;
  logic             r_done, w_done_nxt;
  logic             w_ready_st;
  logic             w_accept;

  // The first bit goes straight to q at acceptance, so the shift register
  // only holds the bits still to come.
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load_shift;
  logic [WIDTH-1:0] w_step_shift;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first_bit  = d_in[WIDTH-1];
      assign w_load_shift = {d_in[WIDTH-2:0], 1'b0};
      assign w_next_bit   = r_shift[WIDTH-1];
      assign w_step_shift = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_first_bit  = d_in[0];
      assign w_load_shift = {1'b0, d_in[WIDTH-1:1]};
      assign w_next_bit   = r_shift[0];
      assign w_step_shift = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

`ifdef PIS_PARITY_EN
  logic r_par, w_par_nxt;
  assign w_ready_st = (r_state == S_IDLE) || (r_state == S_PAR);
`else
  assign w_ready_st = (r_state == S_IDLE) ||
                      ((r_state == S_SHIFT) && (r_cnt == '0));
`endif

  assign w_accept = d_valid && w_ready_st;
  assign d_ready  = w_ready_st && !rst;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_q_nxt     = 1'b0;
    w_frame_nxt = 1'b0;
    w_done_nxt  = 1'b0;
`ifdef PIS_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_SHIFT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt   = r_cnt - c_cnt_one;
          w_shift_nxt = w_step_shift;
          w_q_nxt     = w_next_bit;
          w_frame_nxt = 1'b1;
`ifndef PIS_PARITY_EN
          w_done_nxt  = (r_cnt == c_cnt_one);
`endif
        end else begin
`ifdef PIS_PARITY_EN
          w_state_nxt = S_PAR;
          w_q_nxt     = r_par;
          w_frame_nxt = 1'b1;
          w_done_nxt  = 1'b1;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
      S_PAR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // A new word accepted in the last cycle of a frame takes precedence.
    if (w_accept) begin
      w_state_nxt = S_SHIFT;
      w_cnt_nxt   = c_cnt_max;
      w_shift_nxt = w_load_shift;
      w_q_nxt     = w_first_bit;
      w_frame_nxt = 1'b1;
      w_done_nxt  = 1'b0;
`ifdef PIS_PARITY_EN
      w_par_nxt   = ^d_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_q     <= 1'b0;
      r_frame <= 1'b0;
      r_done  <= 1'b0;
`ifdef PIS_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_q     <= w_q_nxt;
      r_frame <= w_frame_nxt;
      r_done  <= w_done_nxt;
`ifdef PIS_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign q     = r_q;
  assign qb    = ~r_q;
  assign frame = r_frame;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// Testbench for piso_serializer: MSB-first and LSB-first instances driven in
// lockstep and compared cycle by cycle against a queue-based line model.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] d_in;
  logic         d_valid;
  logic         rdy_m, q_m, qb_m, frame_m, done_m;
  logic         rdy_l, q_l, qb_l, frame_l, done_l;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic q;
    logic f;
    logic d;
  } sym_t;

  sym_t exp_m[$];
  sym_t exp_l[$];

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .d_ready(rdy_m),
    .q(q_m), .qb(qb_m), .frame(frame_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .d_ready(rdy_l),
    .q(q_l), .qb(qb_l), .frame(frame_l), .done(done_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A frame is a list of line symbols, one per cycle, in transmit order.
  task automatic push_word(input logic [W-1:0] w);
    sym_t s;
    for (int i = 0; i < W; i++) begin
      s.f = 1'b1;
`ifdef PIS_PARITY_EN
      s.d = 1'b0;
`else
      s.d = (i == W - 1);
`endif
      s.q = w[W-1-i];
      exp_m.push_back(s);
      s.q = w[i];
      exp_l.push_back(s);
    end
`ifdef PIS_PARITY_EN
    s.q = ^w;
    s.f = 1'b1;
    s.d = 1'b1;
    exp_m.push_back(s);
    exp_l.push_back(s);
`endif
  endtask

  task automatic cmp_line(input string tag, input sym_t e, input logic qv,
                          input logic qbv, input logic fv, input logic dv);
    check({tag, "_q"},     {31'd0, qv},  {31'd0, e.q});
    check({tag, "_qb"},    {31'd0, qbv}, {31'd0, ~e.q});
    check({tag, "_frame"}, {31'd0, fv},  {31'd0, e.f});
    check({tag, "_done"},  {31'd0, dv},  {31'd0, e.d});
  endtask

  // One clock cycle: apply inputs, check readiness, advance model, check line.
  task automatic cycle(input logic r, input logic v, input logic [W-1:0] din,
                       output logic acc);
    logic exp_rdy;
    sym_t em, el;
    rst = r;
    d_valid = v;
    d_in = din;
    #1;
    exp_rdy = !r && (exp_m.size() <= 1);
    check("ready_msb", {31'd0, rdy_m}, {31'd0, exp_rdy});
    check("ready_lsb", {31'd0, rdy_l}, {31'd0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge clk);
    if (exp_m.size() > 0) begin
      void'(exp_m.pop_front());
      void'(exp_l.pop_front());
    end
    if (r) begin
      exp_m.delete();
      exp_l.delete();
    end else if (acc) begin
      push_word(din);
    end
    #1;
    em = (exp_m.size() > 0) ? exp_m[0] : 3'b000;
    el = (exp_l.size() > 0) ? exp_l[0] : 3'b000;
    cmp_line("msb", em, q_m, qb_m, frame_m, done_m);
    cmp_line("lsb", el, q_l, qb_l, frame_l, done_l);
  endtask

  // Hold a word until it is taken, with a bounded wait.
  task automatic send(input logic [W-1:0] w);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 4 * W) begin
      cycle(1'b0, 1'b1, w, acc);
      n++;
    end
    check("send_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, W'($urandom), acc);
  endtask

  initial begin
    logic acc;
    rst = 1'b1;
    d_valid = 1'b1;
    d_in = '0;

    // Reset with d_valid held high: nothing may be accepted.
    cycle(1'b1, 1'b1, 8'h3C, acc);
    cycle(1'b1, 1'b1, 8'hC3, acc);
    idle(2);

    send(8'hA5);
    idle(W + 2);

    // Back-to-back: second word accepted in the last-bit cycle.
    send(8'hFF);
    send(8'h00);
    idle(W + 2);

    send(8'h01);
    idle(W + 2);

    send(8'h07);
    idle(W + 2);

    // Changing d_in while not ready must not disturb the current word.
    send(8'h96);
    for (int i = 0; i < W - 2; i++) cycle(1'b0, 1'b1, W'($urandom), acc);
    idle(W + 2);

    // Reset at the 4th bit aborts the word without a done pulse.
    send(8'hB4);
    idle(2);
    cycle(1'b1, 1'b1, 8'h5A, acc);
    idle(W + 2);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0),
            W'($urandom), acc);
    end
    idle(W + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
